snake_render_pipe: RTL

- Parametrised, pipelined pixel renderer for the snake game; next generation of the interface pixel colour stage.
- Sits between the VGA timing generator / snake-body lookup and the VGA output register.
- Maps each (x_pos, y_pos) pixel to a 12-bit RGB value for every game mode, including the start-screen picture from an external ROM.
- Adds a ROM-latency-aligned pipeline, valid tracking and a blinking snake on DIE.

---
 rtl/snake_pkg.sv | 42 ++++
 rtl/snake_pix_delay.sv | 38 +++
 rtl/snake_render_pipe.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared codes, default colours and pipeline tag for the snake pixel renderer.
package snake_pkg;

  typedef enum logic [1:0] {
    CELL_NONE = 2'b00,
    CELL_HEAD = 2'b01,
    CELL_BODY = 2'b10,
    CELL_WALL = 2'b11
  } cell_e;

  typedef enum logic [1:0] {
    ST_RESTART = 2'b00,
    ST_START   = 2'b01,
    ST_PLAY    = 2'b10,
    ST_DIE     = 2'b11
  } status_e;

  typedef enum logic {
    BLINK_SHOW = 1'b0,
    BLINK_HIDE = 1'b1
  } blink_e;

  localparam int ADDR_W = 17;
  localparam int POS_W  = 10;

  localparam logic [11:0] DEF_HEAD_COLOR  = 12'h0F0;
  localparam logic [11:0] DEF_BODY_COLOR  = 12'hFF0;
  localparam logic [11:0] DEF_WALL_COLOR  = 12'hF00;
  localparam logic [11:0] DEF_APPLE_COLOR = 12'h00F;

  // Per-pixel context that rides alongside the ROM access.
  typedef struct packed {
    status_e     mode;
    logic        in_pic;
    logic [11:0] color;
  } pix_tag_t;

  function automatic logic [11:0] expand_pic(input logic [2:0] bgr);
    return {{4{bgr[0]}}, {4{bgr[1]}}, {4{bgr[2]}}};
  endfunction

endpackage

// File: rtl/snake_pix_delay.sv
// Fixed-depth shift register; only the valid bits are cleared by reset.
module snake_pix_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= i_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    r_data[0] <= i_data;
    for (int i = 1; i < DEPTH; i++) begin
      r_data[i] <= r_data[i-1];
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/snake_render_pipe.sv
// Pixel renderer: inputs -> pic_addr (+1 cycle) -> vga_data/vga_valid (+2+ROM_LAT cycles).
// blink state | meaning:  BLINK_SHOW snake drawn  |  BLINK_HIDE head/body blanked in DIE
module snake_render_pipe
  import snake_pkg::*;
#(
  parameter int          CELL_LOG2    = 4,
  parameter int          PIC_X0       = 130,
  parameter int          PIC_Y0       = 120,
  parameter int          PIC_W        = 380,
  parameter int          PIC_H        = 180,
  parameter int          ROM_LAT      = 1,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] HEAD_COLOR   = DEF_HEAD_COLOR,
  parameter logic [11:0] BODY_COLOR   = DEF_BODY_COLOR,
  parameter logic [11:0] WALL_COLOR   = DEF_WALL_COLOR,
  parameter logic [11:0] APPLE_COLOR  = DEF_APPLE_COLOR
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pix_valid,
  input  logic              i_frame_start,
  input  logic [POS_W-1:0]  i_x_pos,
  input  logic [POS_W-1:0]  i_y_pos,
  input  logic [5:0]        i_apple_x,
  input  logic [4:0]        i_apple_y,
  input  logic [1:0]        i_snake,
  input  logic [1:0]        i_game_status,
  output logic [ADDR_W-1:0] o_pic_addr,
  input  logic [2:0]        i_pic_data,
  output logic [11:0]       o_vga_data,
  output logic              o_vga_valid
);

  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int TAG_W   = $bits(pix_tag_t);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [POS_W:0] X_LO = (POS_W+1)'(PIC_X0);
  localparam logic [POS_W:0] X_HI = (POS_W+1)'(PIC_X0 + PIC_W);
  localparam logic [POS_W:0] Y_LO = (POS_W+1)'(PIC_Y0);
  localparam logic [POS_W:0] Y_HI = (POS_W+1)'(PIC_Y0 + PIC_H);

  status_e w_status;
  cell_e   w_cell;
  assign w_status = status_e'(i_game_status);
  assign w_cell   = cell_e'(i_snake);

  // ---------------- blink state ----------------
  blink_e             r_blink_state, w_blink_state_nxt;
  logic [BLINK_W-1:0] r_blink_cnt, w_blink_cnt_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_blink_state <= BLINK_SHOW;
      r_blink_cnt   <= '0;
    end else begin
      r_blink_state <= w_blink_state_nxt;
      r_blink_cnt   <= w_blink_cnt_nxt;
    end
  end

  always_comb begin
    w_blink_state_nxt = r_blink_state;
    w_blink_cnt_nxt   = r_blink_cnt;
    if (w_status != ST_DIE) begin
      w_blink_state_nxt = BLINK_SHOW;
      w_blink_cnt_nxt   = '0;
    end else if (i_frame_start) begin
      if (r_blink_cnt == BLINK_LAST) begin
        w_blink_cnt_nxt   = '0;
        w_blink_state_nxt = (r_blink_state == BLINK_SHOW) ? BLINK_HIDE : BLINK_SHOW;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + 1'b1;
      end
    end
  end

  // ---------------- stage 1: classify and address ----------------
  logic [POS_W-1:0]  w_cell_x, w_cell_y;
  logic              w_apple_hit, w_corner, w_hide, w_in_pic;
  logic [POS_W-1:0]  w_off_x, w_off_y;
  logic [ADDR_W-1:0] w_pic_addr;
  logic [11:0]       w_class_color;
  pix_tag_t          w_s1_tag;

  assign w_cell_x    = i_x_pos >> CELL_LOG2;
  assign w_cell_y    = i_y_pos >> CELL_LOG2;
  assign w_apple_hit = (w_cell_x == POS_W'(i_apple_x)) && (w_cell_y == POS_W'(i_apple_y));
  assign w_corner    = (i_x_pos[CELL_LOG2-1:0] == '0) && (i_y_pos[CELL_LOG2-1:0] == '0);
  assign w_hide      = (w_status == ST_DIE) && (r_blink_state == BLINK_HIDE);

  assign w_in_pic = ({1'b0, i_x_pos} >= X_LO) && ({1'b0, i_x_pos} < X_HI) &&
                    ({1'b0, i_y_pos} >= Y_LO) && ({1'b0, i_y_pos} < Y_HI);
  assign w_off_x    = i_x_pos - X_LO[POS_W-1:0];
  assign w_off_y    = i_y_pos - Y_LO[POS_W-1:0];
  assign w_pic_addr = ADDR_W'(w_off_x) + ADDR_W'(PIC_W) * ADDR_W'(w_off_y);

  // Apple outranks every snake class; wall cells carry no grid dot.
  always_comb begin
    w_class_color = '0;
    if (w_status == ST_PLAY || w_status == ST_DIE) begin
      if (w_apple_hit) begin
        w_class_color = w_corner ? 12'h000 : APPLE_COLOR;
      end else begin
        case (w_cell)
          CELL_WALL: w_class_color = WALL_COLOR;
          CELL_HEAD: w_class_color = (w_corner || w_hide) ? 12'h000 : HEAD_COLOR;
          CELL_BODY: w_class_color = (w_corner || w_hide) ? 12'h000 : BODY_COLOR;
          default:   w_class_color = '0;
        endcase
      end
    end
  end

  assign w_s1_tag = '{mode: w_status, in_pic: w_in_pic, color: w_class_color};

  logic              r_s1_valid;
  pix_tag_t          r_s1_tag;
  logic [ADDR_W-1:0] r_pic_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_tag   <= '0;
      r_pic_addr <= '0;
    end else begin
      r_s1_valid <= i_pix_valid;
      r_s1_tag   <= w_s1_tag;
      if (i_pix_valid && w_status == ST_START && w_in_pic) begin
        r_pic_addr <= w_pic_addr;
      end
    end
  end

  assign o_pic_addr = r_pic_addr;

  // ---------------- align with ROM read latency ----------------
  logic             w_d_valid;
  logic [TAG_W-1:0] w_d_data;
  pix_tag_t         w_d_tag;

  snake_pix_delay #(
    .DEPTH (ROM_LAT),
    .WIDTH (TAG_W)
  ) u_delay (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (r_s1_valid),
    .i_data  (r_s1_tag),
    .o_valid (w_d_valid),
    .o_data  (w_d_data)
  );

  assign w_d_tag = pix_tag_t'(w_d_data);

  // ---------------- output register ----------------
  logic [11:0] r_vga_data;
  logic        r_vga_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vga_data  <= '0;
      r_vga_valid <= 1'b0;
    end else begin
      r_vga_valid <= w_d_valid;
      if (!w_d_valid) begin
        r_vga_data <= '0;
      end else if (w_d_tag.mode == ST_START && w_d_tag.in_pic) begin
        r_vga_data <= expand_pic(i_pic_data);
      end else begin
        r_vga_data <= w_d_tag.color;
      end
    end
  end

  assign o_vga_data  = r_vga_data;
  assign o_vga_valid = r_vga_valid;

endmodule
